// File: rtl/mux_8to1_rr_if.sv
// mux_8to1_rr_if: channel-side and output-side valid/ready bundle
// for the 8-to-1 round-robin merge.
interface mux_8to1_rr_if #(
   parameter int DATA_W = 8
);
   logic [7:0]          in_valid;
   logic [8*DATA_W-1:0] in_data;
   logic [7:0]          in_ready;
   logic                out_valid;
   logic [DATA_W-1:0]   out_data;
   logic [2:0]          out_sel;
   logic                out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel
   );
endinterface

// File: rtl/mux_8to1_rr.sv
// mux_8to1_rr: round-robin 8-to-1 merge with one registered output stage.
// Optional MUX_GRANT_CNT_EN adds the xfer_cnt output-transfer counter.
module mux_8to1_rr #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input logic clk,
   input logic rst,
   mux_8to1_rr_if.slave bus
`ifdef MUX_GRANT_CNT_EN
   ,
   output logic [CNT_W-1:0] xfer_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        ptr;
   logic [2:0]        gnt_idx;
   logic              gnt_found;
   logic              load;
   logic              accept;
   logic [7:0]        ready;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        sel_q;

   assign load          = (state == EMPTY) | bus.out_ready;
   assign accept        = |(bus.in_valid & ready);
   assign bus.in_ready  = ready;
   assign bus.out_valid = (state == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;

   // First valid channel at or after ptr, wrapping mod 8
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!gnt_found && bus.in_valid[ptr + 3'(i)]) begin
            gnt_found = 1'b1;
            gnt_idx   = ptr + 3'(i);
         end
      end
   end

   // One-hot accept; silent in reset or when the output cannot take a word
   always_comb begin
      ready = 8'h00;
      if (!rst && load && gnt_found)
         ready[gnt_idx] = 1'b1;
   end

   // Output register occupancy: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: if (accept) state_nxt = FULL;
         FULL:  if (bus.out_ready && !accept) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // Output register occupancy: state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   // Capture accepted word and advance the round-robin pointer past it
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         sel_q  <= 3'd0;
         ptr    <= 3'd0;
      end else if (accept) begin
         data_q <= bus.in_data[gnt_idx*DATA_W +: DATA_W];
         sel_q  <= gnt_idx;
         ptr    <= gnt_idx + 3'd1;
      end
   end

`ifdef MUX_GRANT_CNT_EN
   // Count output-side transfers, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst)
         xfer_cnt <= '0;
      else if (bus.out_valid && bus.out_ready)
         xfer_cnt <= xfer_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_mux_8to1_rr.sv
// tb_mux_8to1_rr: directed vector table, counter sequence and
// random traffic against a behavioural round-robin model.
module tb_mux_8to1_rr;

   localparam logic [63:0] D = 64'h1716_1514_1312_1110;
   localparam logic [63:0] A = 64'h0000_0000_A500_0000;

   typedef struct {
      logic        r;
      logic [7:0]  iv;
      logic [63:0] d;
      logic        rdy;
      logic [7:0]  ir;
      logic        ov;
      logic [2:0]  sel;
      logic [7:0]  dat;
      logic        cd;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux_8to1_rr_if #(.DATA_W(8)) bus ();

`ifdef MUX_GRANT_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   mux_8to1_rr #(
      .DATA_W(8),
      .CNT_W (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef MUX_GRANT_CNT_EN
      ,
      .xfer_cnt(xfer_cnt)
`endif
   );

   int vecs;
   int errs;

   logic        m_valid;
   logic [7:0]  m_data;
   logic [2:0]  m_sel;
   int          m_ptr;
   logic [15:0] m_cnt;
   logic [7:0]  m_gnt;

   logic        s_rst;
   logic [63:0] s_d;
   logic        s_rdy;

   vec_t tbl[25];

   function automatic logic [7:0] ref_grant(input logic r,
                                            input logic [7:0] iv,
                                            input logic rdy);
      int k;
      if (r) return 8'h00;
      if (m_valid && !rdy) return 8'h00;
      for (int j = 0; j < 8; j++) begin
         k = (m_ptr + j) % 8;
         if (iv[k]) return 8'(1 << k);
      end
      return 8'h00;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic apply(input logic r, input logic [7:0] iv,
                        input logic [63:0] d, input logic rdy);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = rdy;
      s_rst = r;
      s_d   = d;
      s_rdy = rdy;
      #1;
      m_gnt = ref_grant(r, iv, rdy);
      chk("in_ready", 64'(bus.in_ready), 64'(m_gnt));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("out_sel", 64'(bus.out_sel), 64'(m_sel));
      chk("out_data", 64'(bus.out_data), 64'(m_data));
`ifdef MUX_GRANT_CNT_EN
      chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
   endtask

   task automatic advance();
      int kk;
      @(posedge clk);
      if (s_rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_sel   = 3'd0;
         m_ptr   = 0;
         m_cnt   = 16'h0;
      end else begin
         if (m_valid && s_rdy) m_cnt = m_cnt + 16'h1;
         if (m_gnt != 8'h00) begin
            kk = 0;
            for (int k = 0; k < 8; k++)
               if (m_gnt[k]) kk = k;
            m_data  = s_d[kk*8 +: 8];
            m_sel   = 3'(kk);
            m_valid = 1'b1;
            m_ptr   = (kk + 1) % 8;
         end else if (s_rdy) begin
            m_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0]  cur_iv;
      logic [63:0] cur_d;
      logic [12:0] rdy_pat;
      logic        r;
      logic        rdy;

      vecs = 0;
      errs = 0;
      rst           = 1'b1;
      bus.in_valid  = 8'hFF;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 3'd0;
      m_ptr   = 0;
      m_cnt   = 16'h0;
      m_gnt   = 8'h00;
      @(negedge clk);

      tbl[0]  = '{1'b1, 8'hFF, D, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1};
      tbl[1]  = '{1'b1, 8'hFF, D, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1};
      tbl[2]  = '{1'b0, 8'h08, A, 1'b1, 8'h08, 1'b0, 3'd0, 8'h00, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, A, 1'b1, 8'h00, 1'b1, 3'd3, 8'hA5, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, A, 1'b1, 8'h00, 1'b0, 3'd3, 8'hA5, 1'b0};
      tbl[5]  = '{1'b1, 8'h00, D, 1'b1, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
      tbl[6]  = '{1'b0, 8'hFF, D, 1'b1, 8'h01, 1'b0, 3'd0, 8'h00, 1'b1};
      tbl[7]  = '{1'b0, 8'hFF, D, 1'b1, 8'h02, 1'b1, 3'd0, 8'h10, 1'b1};
      tbl[8]  = '{1'b0, 8'hFF, D, 1'b1, 8'h04, 1'b1, 3'd1, 8'h11, 1'b1};
      tbl[9]  = '{1'b0, 8'hFF, D, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12, 1'b1};
      tbl[10] = '{1'b0, 8'hFF, D, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12, 1'b1};
      tbl[11] = '{1'b0, 8'hFF, D, 1'b0, 8'h00, 1'b1, 3'd2, 8'h12, 1'b1};
      tbl[12] = '{1'b0, 8'hFF, D, 1'b1, 8'h08, 1'b1, 3'd2, 8'h12, 1'b1};
      tbl[13] = '{1'b0, 8'hFF, D, 1'b1, 8'h10, 1'b1, 3'd3, 8'h13, 1'b1};
      tbl[14] = '{1'b0, 8'hFF, D, 1'b1, 8'h20, 1'b1, 3'd4, 8'h14, 1'b1};
      tbl[15] = '{1'b0, 8'hFF, D, 1'b1, 8'h40, 1'b1, 3'd5, 8'h15, 1'b1};
      tbl[16] = '{1'b0, 8'hFF, D, 1'b1, 8'h80, 1'b1, 3'd6, 8'h16, 1'b1};
      tbl[17] = '{1'b0, 8'hFF, D, 1'b1, 8'h01, 1'b1, 3'd7, 8'h17, 1'b1};
      tbl[18] = '{1'b0, 8'h00, D, 1'b1, 8'h00, 1'b1, 3'd0, 8'h10, 1'b1};
      tbl[19] = '{1'b0, 8'h80, D, 1'b1, 8'h80, 1'b0, 3'd0, 8'h10, 1'b0};
      tbl[20] = '{1'b0, 8'h41, D, 1'b1, 8'h01, 1'b1, 3'd7, 8'h17, 1'b1};
      tbl[21] = '{1'b0, 8'h40, D, 1'b1, 8'h40, 1'b1, 3'd0, 8'h10, 1'b1};
      tbl[22] = '{1'b0, 8'h00, D, 1'b1, 8'h00, 1'b1, 3'd6, 8'h16, 1'b1};
      tbl[23] = '{1'b0, 8'hFF, D, 1'b1, 8'h80, 1'b0, 3'd6, 8'h16, 1'b0};
      tbl[24] = '{1'b0, 8'h00, D, 1'b1, 8'h00, 1'b1, 3'd7, 8'h17, 1'b1};

      for (int i = 0; i < 25; i++) begin
         apply(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].rdy);
         chk($sformatf("tbl%0d_in_ready", i),
             64'(bus.in_ready), 64'(tbl[i].ir));
         chk($sformatf("tbl%0d_out_valid", i),
             64'(bus.out_valid), 64'(tbl[i].ov));
         if (tbl[i].cd) begin
            chk($sformatf("tbl%0d_out_sel", i),
                64'(bus.out_sel), 64'(tbl[i].sel));
            chk($sformatf("tbl%0d_out_data", i),
                64'(bus.out_data), 64'(tbl[i].dat));
         end
         advance();
      end

`ifdef MUX_GRANT_CNT_EN
      apply(1'b1, 8'h00, D, 1'b1);
      advance();
      apply(1'b0, 8'hFF, D, 1'b1);
      advance();
      rdy_pat = 13'b1111_0110_1101_1;
      for (int i = 0; i < 13; i++) begin
         apply(1'b0, 8'hFF, D, rdy_pat[i]);
         advance();
      end
      apply(1'b1, 8'h00, D, 1'b1);
      chk("cnt_after_10", 64'(xfer_cnt), 64'd10);
      advance();
      apply(1'b0, 8'h00, D, 1'b0);
      chk("cnt_after_rst", 64'(xfer_cnt), 64'd0);
      advance();
`else
      rdy_pat = 13'h0;
`endif

      cur_iv = 8'h00;
      cur_d  = '0;
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 63) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         apply(r, cur_iv, cur_d, rdy);
         advance();
         for (int k = 0; k < 8; k++) begin
            if (!cur_iv[k] || m_gnt[k]) begin
               cur_iv[k]         = 1'($urandom_range(0, 1));
               cur_d[k*8 +: 8]   = 8'($urandom);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
